stoat_wb_arbiter: RTL and testbench

Two-master to one-slave pipelined Wishbone arbiter. The stoat core's ibus (read-only) and dbus (read-write) share one memory port.

---
 rtl/stoat_arb_pkg.sv | 13 +
 rtl/stoat_wb_txn_counter.sv | 36 +++
 rtl/stoat_wb_arbiter.sv | 141 ++++++++++++++
 tb/tb_stoat_wb_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stoat_arb_pkg.sv
// Shared types for the stoat Wishbone arbiter: grant state encoding and the
// fixed ibus byte-select.
package stoat_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GNT_I = 2'd1,
        ARB_GNT_D = 2'd2
    } arb_state_t;

    localparam logic [3:0] ARB_IBUS_SEL = 4'hF;

endpackage

// File: rtl/stoat_wb_txn_counter.sv
// Saturating up/down count of accepted-but-unacked bus requests; the clear
// input drops everything in flight when a grant is released.
module stoat_wb_txn_counter #(
    parameter  int MAX_COUNT = 4,
    localparam int CW        = $clog2(MAX_COUNT + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clr,
    input  logic          i_inc,
    input  logic          i_dec,
    output logic [CW-1:0] o_cnt,
    output logic          o_full,
    output logic          o_empty
);

    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_COUNT);

    logic [CW-1:0] cnt;

    assign o_cnt   = cnt;
    assign o_full  = (cnt == MAX_CNT);
    assign o_empty = (cnt == '0);

    // Simultaneous inc and dec cancel; the ends saturate instead of wrapping.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            cnt <= '0;
        end else if (i_inc && !i_dec && !o_full) begin
            cnt <= cnt + CW'(1);
        end else if (i_dec && !i_inc && !o_empty) begin
            cnt <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/stoat_wb_arbiter.sv
// Two-master (ibus read-only, dbus read-write) to one-slave pipelined Wishbone
// arbiter. Define STOAT_ARB_ROUND_ROBIN_EN for round-robin tie breaking.
module stoat_wb_arbiter
    import stoat_arb_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_ibus_cyc,
    input  logic        i_ibus_stb,
    input  logic [31:0] i_ibus_addr,
    output logic        o_ibus_ack,
    output logic        o_ibus_stall,
    output logic [31:0] o_ibus_data_miso,
    input  logic        i_dbus_cyc,
    input  logic        i_dbus_stb,
    input  logic        i_dbus_we,
    input  logic [3:0]  i_dbus_sel,
    input  logic [31:0] i_dbus_addr,
    input  logic [31:0] i_dbus_data_mosi,
    output logic        o_dbus_ack,
    output logic        o_dbus_stall,
    output logic [31:0] o_dbus_data_miso,
    output logic        o_mem_cyc,
    output logic        o_mem_stb,
    output logic        o_mem_we,
    output logic [3:0]  o_mem_sel,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_data_mosi,
    input  logic        i_mem_ack,
    input  logic        i_mem_stall,
    input  logic [31:0] i_mem_data_miso
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    arb_state_t    state, state_nxt;
    logic [CW-1:0] cnt;
    logic          cnt_full, cnt_empty;
    logic          accept, ack_valid, release_gnt;
    logic          pick_d;

`ifdef STOAT_ARB_ROUND_ROBIN_EN
    logic last_d;

    // On a tie, favour whichever master was not served last.
    assign pick_d = i_dbus_cyc && (!i_ibus_cyc || !last_d);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            last_d <= 1'b0;
        end else if (state == ARB_IDLE && state_nxt != ARB_IDLE) begin
            last_d <= (state_nxt == ARB_GNT_D);
        end
    end
`else
    assign pick_d = i_dbus_cyc;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A grant is held until its owner drops cyc; handover always goes via IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE: begin
                if (pick_d) begin
                    state_nxt = ARB_GNT_D;
                end else if (i_ibus_cyc) begin
                    state_nxt = ARB_GNT_I;
                end
            end
            ARB_GNT_I: if (!i_ibus_cyc) state_nxt = ARB_IDLE;
            ARB_GNT_D: if (!i_dbus_cyc) state_nxt = ARB_IDLE;
            default:   state_nxt = ARB_IDLE;
        endcase
    end

    always_comb begin
        o_mem_cyc       = 1'b0;
        o_mem_stb       = 1'b0;
        o_mem_we        = 1'b0;
        o_mem_sel       = 4'h0;
        o_mem_addr      = 32'h0;
        o_mem_data_mosi = 32'h0;
        o_ibus_stall    = 1'b1;
        o_dbus_stall    = 1'b1;
        o_ibus_ack      = 1'b0;
        o_dbus_ack      = 1'b0;
        case (state)
            ARB_GNT_I: begin
                o_mem_cyc    = i_ibus_cyc;
                o_mem_stb    = i_ibus_stb && !cnt_full;
                o_mem_sel    = ARB_IBUS_SEL;
                o_mem_addr   = i_ibus_addr;
                o_ibus_stall = i_mem_stall || cnt_full;
                o_ibus_ack   = i_mem_ack && i_ibus_cyc && !cnt_empty;
            end
            ARB_GNT_D: begin
                o_mem_cyc       = i_dbus_cyc;
                o_mem_stb       = i_dbus_stb && !cnt_full;
                o_mem_we        = i_dbus_we;
                o_mem_sel       = i_dbus_sel;
                o_mem_addr      = i_dbus_addr;
                o_mem_data_mosi = i_dbus_data_mosi;
                o_dbus_stall    = i_mem_stall || cnt_full;
                o_dbus_ack      = i_mem_ack && i_dbus_cyc && !cnt_empty;
            end
            default: ;
        endcase
    end

    assign o_ibus_data_miso = i_mem_data_miso;
    assign o_dbus_data_miso = i_mem_data_miso;

    assign accept      = o_mem_stb && !i_mem_stall;
    assign ack_valid   = o_ibus_ack || o_dbus_ack;
    assign release_gnt = (state == ARB_GNT_I && !i_ibus_cyc) ||
                         (state == ARB_GNT_D && !i_dbus_cyc);

    stoat_wb_txn_counter #(
        .MAX_COUNT (MAX_OUTSTANDING)
    ) u_txn_cnt (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clr   (release_gnt),
        .i_inc   (accept),
        .i_dec   (ack_valid),
        .o_cnt   (cnt),
        .o_full  (cnt_full),
        .o_empty (cnt_empty)
    );

endmodule

// File: tb/tb_stoat_wb_arbiter.sv
// Directed bench for stoat_wb_arbiter: a transaction-level model is checked
// against every output each cycle, plus hand-computed spot checks.
module tb_stoat_wb_arbiter;

    localparam int MAXO = 4;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_ibus_cyc = 0, i_ibus_stb = 0;
    logic [31:0] i_ibus_addr = 0;
    logic        o_ibus_ack, o_ibus_stall;
    logic [31:0] o_ibus_data_miso;
    logic        i_dbus_cyc = 0, i_dbus_stb = 0, i_dbus_we = 0;
    logic [3:0]  i_dbus_sel = 0;
    logic [31:0] i_dbus_addr = 0, i_dbus_data_mosi = 0;
    logic        o_dbus_ack, o_dbus_stall;
    logic [31:0] o_dbus_data_miso;
    logic        o_mem_cyc, o_mem_stb, o_mem_we;
    logic [3:0]  o_mem_sel;
    logic [31:0] o_mem_addr, o_mem_data_mosi;
    logic        i_mem_ack = 0, i_mem_stall = 0;
    logic [31:0] i_mem_data_miso = 0;

    int checks = 0;
    int errors = 0;

    stoat_wb_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_ibus_cyc(i_ibus_cyc), .i_ibus_stb(i_ibus_stb), .i_ibus_addr(i_ibus_addr),
        .o_ibus_ack(o_ibus_ack), .o_ibus_stall(o_ibus_stall), .o_ibus_data_miso(o_ibus_data_miso),
        .i_dbus_cyc(i_dbus_cyc), .i_dbus_stb(i_dbus_stb), .i_dbus_we(i_dbus_we),
        .i_dbus_sel(i_dbus_sel), .i_dbus_addr(i_dbus_addr), .i_dbus_data_mosi(i_dbus_data_mosi),
        .o_dbus_ack(o_dbus_ack), .o_dbus_stall(o_dbus_stall), .o_dbus_data_miso(o_dbus_data_miso),
        .o_mem_cyc(o_mem_cyc), .o_mem_stb(o_mem_stb), .o_mem_we(o_mem_we),
        .o_mem_sel(o_mem_sel), .o_mem_addr(o_mem_addr), .o_mem_data_mosi(o_mem_data_mosi),
        .i_mem_ack(i_mem_ack), .i_mem_stall(i_mem_stall), .i_mem_data_miso(i_mem_data_miso)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Model: owner 0=none 1=ibus 2=dbus, count of in-flight requests,
    // and which master was served last (for round-robin ties).
    int m_own = 0, m_cnt = 0, m_last = 1;
    int n_own = 0, n_cnt = 0, n_last = 1;
    bit model_ok = 0;

    always @(negedge i_clk) begin
        logic        e_cyc, e_stb, e_we, e_ia, e_da, e_is, e_ds;
        logic [3:0]  e_sel;
        logic [31:0] e_addr, e_mosi;
        bit          x_cyc, x_stb, tie_to_i;
        int          acc, ackv;
        if (model_ok) begin
            e_cyc = 0; e_stb = 0; e_we = 0; e_sel = 0; e_addr = 0; e_mosi = 0;
            e_ia = 0; e_da = 0; e_is = 1; e_ds = 1;
            x_cyc = (m_own == 1) ? i_ibus_cyc : i_dbus_cyc;
            x_stb = (m_own == 1) ? i_ibus_stb : i_dbus_stb;
            if (m_own != 0) begin
                e_cyc = x_cyc;
                e_stb = x_stb && (m_cnt < MAXO);
                if (m_own == 1) begin
                    e_sel  = 4'hF;
                    e_addr = i_ibus_addr;
                    e_is   = i_mem_stall || (m_cnt == MAXO);
                    e_ia   = i_mem_ack && x_cyc && (m_cnt != 0);
                end else begin
                    e_we   = i_dbus_we;
                    e_sel  = i_dbus_sel;
                    e_addr = i_dbus_addr;
                    e_mosi = i_dbus_data_mosi;
                    e_ds   = i_mem_stall || (m_cnt == MAXO);
                    e_da   = i_mem_ack && x_cyc && (m_cnt != 0);
                end
            end
            check("mem_cyc", o_mem_cyc, e_cyc);
            check("mem_stb", o_mem_stb, e_stb);
            check("mem_we", o_mem_we, e_we);
            check("mem_sel", o_mem_sel, e_sel);
            check("mem_addr", o_mem_addr, e_addr);
            check("mem_mosi", o_mem_data_mosi, e_mosi);
            check("ibus_ack", o_ibus_ack, e_ia);
            check("dbus_ack", o_dbus_ack, e_da);
            check("ibus_stall", o_ibus_stall, e_is);
            check("dbus_stall", o_dbus_stall, e_ds);
            check("ibus_miso", o_ibus_data_miso, i_mem_data_miso);
            check("dbus_miso", o_dbus_data_miso, i_mem_data_miso);

            n_own = m_own; n_cnt = m_cnt; n_last = m_last;
            if (m_own == 0) begin
`ifdef STOAT_ARB_ROUND_ROBIN_EN
                tie_to_i = (m_last == 2);
`else
                tie_to_i = 0;
`endif
                if (i_dbus_cyc && !(i_ibus_cyc && tie_to_i)) n_own = 2;
                else if (i_ibus_cyc) n_own = 1;
                if (n_own != 0) n_last = n_own;
            end else if (!x_cyc) begin
                n_own = 0;
                n_cnt = 0;
            end else begin
                acc  = (e_stb && !i_mem_stall) ? 1 : 0;
                ackv = (e_ia || e_da) ? 1 : 0;
                n_cnt = m_cnt + acc - ackv;
            end
        end
    end

    always @(posedge i_clk) begin
        if (i_rst) begin
            m_own <= 0; m_cnt <= 0; m_last <= 1; model_ok <= 1;
        end else if (model_ok) begin
            m_own <= n_own; m_cnt <= n_cnt; m_last <= n_last;
        end
    end

    initial begin
        int exp_seq[4];
        int got;
        bit found;

        step(); step();
        check("rst_mem_cyc", o_mem_cyc, 0);
        check("rst_ibus_stall", o_ibus_stall, 1);
        check("rst_dbus_stall", o_dbus_stall, 1);

        // ibus single read
        i_rst = 0;
        i_ibus_cyc = 1; i_ibus_stb = 1; i_ibus_addr = 32'h100;
        step();
        check("i_gnt_stb", o_mem_stb, 1);
        check("i_gnt_addr", o_mem_addr, 32'h100);
        check("i_gnt_we", o_mem_we, 0);
        check("i_gnt_sel", o_mem_sel, 4'hF);
        step();
        i_ibus_stb = 0;
        i_mem_ack = 1; i_mem_data_miso = 32'hDEADBEEF;
        #1;
        check("i_ack", o_ibus_ack, 1);
        check("i_data", o_ibus_data_miso, 32'hDEADBEEF);
        step();
        i_mem_ack = 0; i_ibus_cyc = 0;
        step();

        // simultaneous request: dbus first, ibus after one idle cycle
        i_ibus_cyc = 1; i_dbus_cyc = 1;
        step();
        check("tie_dbus_gnt", o_dbus_stall, 0);
        check("tie_ibus_wait", o_ibus_stall, 1);
        step(); step();
        check("tie_ibus_hold", o_ibus_stall, 1);
        i_dbus_cyc = 0;
        step();
        check("handover_idle", o_mem_cyc, 0);
        step();
        check("handover_ibus", o_ibus_stall, 0);
        check("handover_cyc", o_mem_cyc, 1);
        i_ibus_cyc = 0;
        step();

        // outstanding limit
        i_dbus_cyc = 1; i_dbus_stb = 1; i_dbus_we = 1; i_dbus_sel = 4'h3;
        i_dbus_addr = 32'h200; i_dbus_data_mosi = 32'h55;
        step();
        check("d_we", o_mem_we, 1);
        check("d_sel", o_mem_sel, 4'h3);
        for (int k = 0; k < 4; k++) step();
        check("full_stall", o_dbus_stall, 1);
        check("full_stb", o_mem_stb, 0);
        check("model_cnt_full", m_cnt, 4);
        i_mem_ack = 1;
        #1;
        check("full_ack", o_dbus_ack, 1);
        step();
        i_mem_ack = 0;
        #1;
        check("after_ack_stall", o_dbus_stall, 0);
        check("after_ack_stb", o_mem_stb, 1);
        step();
        i_dbus_stb = 0; i_mem_ack = 1;
        step(); step();
        i_mem_ack = 0;
        check("model_cnt_two", m_cnt, 2);

        // release with requests in flight
        i_dbus_cyc = 0;
        step();
        i_mem_ack = 1;
        #1;
        check("abandon_dack", o_dbus_ack, 0);
        check("abandon_iack", o_ibus_ack, 0);
        step();
        i_mem_ack = 0;

        // reset mid-transfer
        i_dbus_cyc = 1; i_dbus_stb = 1;
        step();
        for (int k = 0; k < 3; k++) step();
        i_dbus_stb = 0;
        check("model_cnt_three", m_cnt, 3);
        i_rst = 1;
        step();
        check("midrst_cyc", o_mem_cyc, 0);
        check("midrst_istall", o_ibus_stall, 1);
        check("midrst_dstall", o_dbus_stall, 1);
        i_rst = 0; i_dbus_cyc = 0; i_mem_ack = 1;
        #1;
        check("midrst_dack", o_dbus_ack, 0);
        check("midrst_iack", o_ibus_ack, 0);
        step();
        i_mem_ack = 0;

        // both masters keep re-requesting
`ifdef STOAT_ARB_ROUND_ROBIN_EN
        exp_seq = '{2, 1, 2, 1};
`else
        exp_seq = '{2, 2, 2, 2};
`endif
        i_ibus_cyc = 1; i_dbus_cyc = 1;
        for (int g = 0; g < 4; g++) begin
            found = 0; got = 0;
            for (int t = 0; t < 6 && !found; t++) begin
                step();
                if (!o_dbus_stall) begin got = 2; found = 1; end
                else if (!o_ibus_stall) begin got = 1; found = 1; end
            end
            check($sformatf("grant_%0d", g), got, exp_seq[g]);
            if (got == 2) i_dbus_cyc = 0;
            else i_ibus_cyc = 0;
            step();
            i_dbus_cyc = 1; i_ibus_cyc = 1;
        end
        i_dbus_cyc = 0; i_ibus_cyc = 0;
        step(); step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
